apb_master_bridge: RTL and testbench

Single-outstanding bridge from the core-side req/gnt/rvalid data interface to APB3. It is the initiator for the peripheral bus: its APB master port drives the slave port of the peripheral bus wrapper, which decodes to UART, GPIO, SPI, timer, event unit, I2C, FLL, SoC control, debug, SPI accelerator and 7-segment control. It sequences SETUP/ACCESS phases, honours PREADY wait states, reports PSLVERR, and aborts transfers to hung slaves with a timeout.

---
 rtl/apb_master_bridge_pkg.sv | 18 +
 rtl/apb_master_bridge_if.sv | 27 ++
 rtl/apb_master_bridge.sv | 152 +++++++++++++++
 tb/tb_apb_master_bridge.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/apb_master_bridge_pkg.sv
// Shared types and constants for the core-to-APB3 master bridge.
package apb_master_bridge_pkg;

  // Bridge sequencing states
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SETUP    = 2'd1,
    ACCESS   = 2'd2,
    ERR_RESP = 2'd3
  } state_t;

  // Byte-enable pattern of a full-word write; any other write is refused
  localparam logic [3:0] BE_FULL = 4'hF;

  // Default ACCESS-phase limit before a hung slave is abandoned
  localparam int unsigned DEFAULT_TIMEOUT = 256;

endpackage : apb_master_bridge_pkg

// File: rtl/apb_master_bridge_if.sv
// APB3 bus bundle; the bridge drives it through the Master modport and the
// peripheral bus wrapper receives it through the Slave modport.
interface APB_BUS #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);

  logic [ADDR_WIDTH-1:0] paddr;
  logic [DATA_WIDTH-1:0] pwdata;
  logic                  pwrite;
  logic                  psel;
  logic                  penable;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pready;
  logic                  pslverr;

  modport Master (
    output paddr, pwdata, pwrite, psel, penable,
    input  prdata, pready, pslverr
  );

  modport Slave (
    input  paddr, pwdata, pwrite, psel, penable,
    output prdata, pready, pslverr
  );

endinterface : APB_BUS

// File: rtl/apb_master_bridge.sv
// Single-outstanding bridge from the core req/gnt/rvalid interface to APB3.
// Sequences SETUP/ACCESS, honours PREADY wait states, reports PSLVERR and
// abandons a transfer to a hung slave after TIMEOUT_CYCLES ACCESS cycles.
module apb_master_bridge
  import apb_master_bridge_pkg::*;
#(
  parameter int unsigned APB_ADDR_WIDTH = 32,
  parameter int unsigned APB_DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      req_i,
  input  logic [APB_ADDR_WIDTH-1:0] addr_i,
  input  logic                      we_i,
  input  logic [3:0]                be_i,
  input  logic [APB_DATA_WIDTH-1:0] wdata_i,
  output logic                      gnt_o,
  output logic                      rvalid_o,
  output logic [APB_DATA_WIDTH-1:0] rdata_o,
  output logic                      err_o,
  APB_BUS.Master                    apb_master
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [APB_ADDR_WIDTH-1:0] ADDR_MASK = ~APB_ADDR_WIDTH'(3);

  state_t                    r_state;
  state_t                    w_next_state;
  logic [CNT_W-1:0]          r_wait_cnt;
  logic [APB_ADDR_WIDTH-1:0] r_addr;
  logic [APB_DATA_WIDTH-1:0] r_wdata;
  logic                      r_we;
  logic                      r_rvalid;
  logic [APB_DATA_WIDTH-1:0] r_rdata;
  logic                      r_err;

  logic                      w_gnt;
  logic                      w_capture;
  logic                      w_psel;
  logic                      w_penable;
  logic                      w_done;
  logic                      w_done_err;
  logic [APB_DATA_WIDTH-1:0] w_done_rdata;

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= IDLE;
    else         r_state <= w_next_state;
  end

  // Next-state and per-state control decode
  always_comb begin
    w_next_state = r_state;
    w_gnt        = 1'b0;
    w_capture    = 1'b0;
    w_psel       = 1'b0;
    w_penable    = 1'b0;
    w_done       = 1'b0;
    w_done_err   = 1'b0;
    w_done_rdata = '0;
    unique case (r_state)
      IDLE: begin
        w_gnt = req_i;
        if (req_i) begin
          w_capture = 1'b1;
          if (we_i && (be_i != BE_FULL)) w_next_state = ERR_RESP;
          else                           w_next_state = SETUP;
        end
      end
      SETUP: begin
        w_psel       = 1'b1;
        w_next_state = ACCESS;
      end
      ACCESS: begin
        w_psel    = 1'b1;
        w_penable = 1'b1;
        // A late PREADY on the final allowed cycle still completes normally
        if (apb_master.pready) begin
          w_done       = 1'b1;
          w_done_err   = apb_master.pslverr;
          w_done_rdata = r_we ? '0 : apb_master.prdata;
          w_next_state = IDLE;
        end else if (r_wait_cnt == CNT_MAX) begin
          w_done       = 1'b1;
          w_done_err   = 1'b1;
          w_next_state = IDLE;
        end
      end
      ERR_RESP: begin
        w_done       = 1'b1;
        w_done_err   = 1'b1;
        w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // ACCESS wait counter: cleared entering SETUP, saturates at the limit
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wait_cnt <= '0;
    end else if (w_next_state == SETUP) begin
      r_wait_cnt <= '0;
    end else if ((r_state == ACCESS) && !apb_master.pready && (r_wait_cnt != CNT_MAX)) begin
      r_wait_cnt <= r_wait_cnt + 1'b1;
    end
  end

  // Request capture on grant; held stable for the whole APB transfer
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_we    <= 1'b0;
    end else if (w_capture) begin
      r_addr  <= addr_i & ADDR_MASK;
      r_wdata <= wdata_i;
      r_we    <= we_i;
    end
  end

  // Registered response; data and error hold until the next completion
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
    end else begin
      r_rvalid <= w_done;
      if (w_done) begin
        r_rdata <= w_done_rdata;
        r_err   <= w_done_err;
      end
    end
  end

  assign gnt_o    = w_gnt;
  assign rvalid_o = r_rvalid;
  assign rdata_o  = r_rdata;
  assign err_o    = r_err;

  // psel/penable decode straight from the async-reset state register so
  // they fall the instant rst_ni is asserted
  assign apb_master.paddr   = r_addr;
  assign apb_master.pwdata  = r_wdata;
  assign apb_master.pwrite  = r_we;
  assign apb_master.psel    = w_psel;
  assign apb_master.penable = w_penable;

endmodule : apb_master_bridge

// File: tb/tb_apb_master_bridge.sv
// Directed self-checking bench for apb_master_bridge with TIMEOUT_CYCLES=16.
module tb_apb_master_bridge;

  localparam int unsigned TO = 16;

  logic        clk;
  logic        rst_n;
  logic        req;
  logic [31:0] addr;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;

  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;

  APB_BUS #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) apb ();

  apb_master_bridge #(
    .APB_ADDR_WIDTH(32),
    .APB_DATA_WIDTH(32),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .req_i      (req),
    .addr_i     (addr),
    .we_i       (we),
    .be_i       (be),
    .wdata_i    (wdata),
    .gnt_o      (gnt),
    .rvalid_o   (rvalid),
    .rdata_o    (rdata),
    .err_o      (err),
    .apb_master (apb.Master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request in the current (IDLE) cycle
  task automatic drive_req(input logic w, input logic [31:0] a, input logic [3:0] b, input logic [31:0] d);
    req = 1'b1; we = w; addr = a; be = b; wdata = d;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = 1'b0; we = 1'b0; addr = '0; be = '0; wdata = '0;
    apb.prdata = '0; apb.pready = 1'b0; apb.pslverr = 1'b0;
    repeat (2) tick();
    n_cmp++; if (apb.psel !== 1'b0)    begin n_fail++; $display("FAIL reset_psel: got %b want 0", apb.psel); end
    n_cmp++; if (apb.penable !== 1'b0) begin n_fail++; $display("FAIL reset_penable: got %b want 0", apb.penable); end
    n_cmp++; if (rvalid !== 1'b0)      begin n_fail++; $display("FAIL reset_rvalid: got %b want 0", rvalid); end
    n_cmp++; if (err !== 1'b0)         begin n_fail++; $display("FAIL reset_err: got %b want 0", err); end
    n_cmp++; if (rdata !== 32'h0)      begin n_fail++; $display("FAIL reset_rdata: got %h want 0", rdata); end
    n_cmp++; if (apb.paddr !== 32'h0)  begin n_fail++; $display("FAIL reset_paddr: got %h want 0", apb.paddr); end
    n_cmp++; if (apb.pwdata !== 32'h0) begin n_fail++; $display("FAIL reset_pwdata: got %h want 0", apb.pwdata); end
    n_cmp++; if (apb.pwrite !== 1'b0)  begin n_fail++; $display("FAIL reset_pwrite: got %b want 0", apb.pwrite); end
    n_cmp++; if (gnt !== 1'b0)         begin n_fail++; $display("FAIL reset_gnt: got %b want 0", gnt); end
    rst_n = 1'b1;
    tick();
    n_cmp++; if (gnt !== 1'b0)         begin n_fail++; $display("FAIL idle_gnt_noreq: got %b want 0", gnt); end
  endtask

  task automatic test_read_zero_wait();
    drive_req(1'b0, 32'h1A10_0004, 4'hF, 32'h0);
    n_cmp++; if (gnt !== 1'b1) begin n_fail++; $display("FAIL rd0_gnt: got %b want 1", gnt); end
    tick(); req = 1'b0;
    n_cmp++; if (apb.psel !== 1'b1 || apb.penable !== 1'b0) begin n_fail++; $display("FAIL rd0_setup: psel/penable %b%b want 10", apb.psel, apb.penable); end
    n_cmp++; if (apb.paddr !== 32'h1A10_0004) begin n_fail++; $display("FAIL rd0_paddr: got %h want 1a100004", apb.paddr); end
    n_cmp++; if (apb.pwrite !== 1'b0) begin n_fail++; $display("FAIL rd0_pwrite: got %b want 0", apb.pwrite); end
    n_cmp++; if (gnt !== 1'b0) begin n_fail++; $display("FAIL rd0_busy_gnt: got %b want 0", gnt); end
    apb.pready = 1'b1; apb.prdata = 32'hCAFE_0001; apb.pslverr = 1'b0;
    tick();
    n_cmp++; if (apb.psel !== 1'b1 || apb.penable !== 1'b1) begin n_fail++; $display("FAIL rd0_access: psel/penable %b%b want 11", apb.psel, apb.penable); end
    n_cmp++; if (rvalid !== 1'b0) begin n_fail++; $display("FAIL rd0_early_rvalid: got %b want 0", rvalid); end
    tick();
    apb.pready = 1'b0;
    n_cmp++; if (rvalid !== 1'b1) begin n_fail++; $display("FAIL rd0_rvalid: got %b want 1", rvalid); end
    n_cmp++; if (rdata !== 32'hCAFE_0001) begin n_fail++; $display("FAIL rd0_rdata: got %h want cafe0001", rdata); end
    n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL rd0_err: got %b want 0", err); end
    n_cmp++; if (apb.psel !== 1'b0) begin n_fail++; $display("FAIL rd0_idle_psel: got %b want 0", apb.psel); end
    tick();
    n_cmp++; if (rvalid !== 1'b0) begin n_fail++; $display("FAIL rd0_rvalid_pulse: got %b want 0", rvalid); end
  endtask

  task automatic test_write_waits();
    drive_req(1'b1, 32'h1A10_100B, 4'hF, 32'h0000_00A5);
    n_cmp++; if (gnt !== 1'b1) begin n_fail++; $display("FAIL wr_gnt: got %b want 1", gnt); end
    tick(); req = 1'b0; wdata = 32'hFFFF_FFFF; addr = 32'h0;
    apb.prdata = 32'hDEAD_BEEF; apb.pready = 1'b0;
    tick();
    // cycles 2..5 are ACCESS; pready raised in cycle 5
    for (int c = 2; c <= 5; c++) begin
      n_cmp++; if (apb.psel !== 1'b1 || apb.penable !== 1'b1) begin n_fail++; $display("FAIL wr_access_c%0d: psel/penable %b%b want 11", c, apb.psel, apb.penable); end
      n_cmp++; if (apb.paddr !== 32'h1A10_1008 || apb.pwdata !== 32'hA5 || apb.pwrite !== 1'b1) begin n_fail++; $display("FAIL wr_stable_c%0d: paddr %h pwdata %h pwrite %b want 1a101008 000000a5 1", c, apb.paddr, apb.pwdata, apb.pwrite); end
      n_cmp++; if (rvalid !== 1'b0) begin n_fail++; $display("FAIL wr_early_rvalid_c%0d: got %b want 0", c, rvalid); end
      if (c == 5) apb.pready = 1'b1;
      tick();
    end
    apb.pready = 1'b0;
    n_cmp++; if (rvalid !== 1'b1) begin n_fail++; $display("FAIL wr_rvalid: got %b want 1", rvalid); end
    n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL wr_err: got %b want 0", err); end
    n_cmp++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL wr_rdata: got %h want 0", rdata); end
    tick();
  endtask

  task automatic test_pslverr();
    drive_req(1'b0, 32'h1A10_2000, 4'h0, 32'h0);
    tick(); req = 1'b0;
    apb.pready = 1'b1; apb.prdata = 32'h1234_5678; apb.pslverr = 1'b1;
    tick(); tick();
    apb.pready = 1'b0; apb.pslverr = 1'b0;
    n_cmp++; if (rvalid !== 1'b1) begin n_fail++; $display("FAIL slverr_rvalid: got %b want 1", rvalid); end
    n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL slverr_err: got %b want 1", err); end
    n_cmp++; if (rdata !== 32'h1234_5678) begin n_fail++; $display("FAIL slverr_rdata: got %h want 12345678", rdata); end
    tick();
    n_cmp++; if (err !== 1'b1 || rdata !== 32'h1234_5678) begin n_fail++; $display("FAIL slverr_hold: err %b rdata %h want 1 12345678", err, rdata); end
  endtask

  task automatic test_partial_write();
    drive_req(1'b1, 32'h1A10_3000, 4'h3, 32'h5A5A_5A5A);
    n_cmp++; if (gnt !== 1'b1) begin n_fail++; $display("FAIL pw_gnt: got %b want 1", gnt); end
    tick(); req = 1'b0;
    n_cmp++; if (apb.psel !== 1'b0) begin n_fail++; $display("FAIL pw_psel_c1: got %b want 0", apb.psel); end
    n_cmp++; if (rvalid !== 1'b0) begin n_fail++; $display("FAIL pw_early_rvalid: got %b want 0", rvalid); end
    tick();
    n_cmp++; if (apb.psel !== 1'b0) begin n_fail++; $display("FAIL pw_psel_c2: got %b want 0", apb.psel); end
    n_cmp++; if (rvalid !== 1'b1 || err !== 1'b1 || rdata !== 32'h0) begin n_fail++; $display("FAIL pw_resp: rvalid %b err %b rdata %h want 1 1 0", rvalid, err, rdata); end
    tick();
  endtask

  task automatic test_timeout();
    drive_req(1'b0, 32'h1A10_4000, 4'hF, 32'h0);
    tick(); req = 1'b0; apb.pready = 1'b0;
    tick();
    for (int c = 1; c <= int'(TO); c++) begin
      n_cmp++; if (apb.psel !== 1'b1 || apb.penable !== 1'b1 || rvalid !== 1'b0) begin n_fail++; $display("FAIL to_access%0d: psel %b penable %b rvalid %b want 1 1 0", c, apb.psel, apb.penable, rvalid); end
      tick();
    end
    n_cmp++; if (apb.psel !== 1'b0 || apb.penable !== 1'b0) begin n_fail++; $display("FAIL to_drop: psel/penable %b%b want 00", apb.psel, apb.penable); end
    n_cmp++; if (rvalid !== 1'b1 || err !== 1'b1 || rdata !== 32'h0) begin n_fail++; $display("FAIL to_resp: rvalid %b err %b rdata %h want 1 1 0", rvalid, err, rdata); end
    // following request completes normally
    drive_req(1'b0, 32'h1A10_4004, 4'hF, 32'h0);
    n_cmp++; if (gnt !== 1'b1) begin n_fail++; $display("FAIL to_next_gnt: got %b want 1", gnt); end
    tick(); req = 1'b0;
    apb.pready = 1'b1; apb.prdata = 32'h0BAD_F00D;
    tick(); tick();
    apb.pready = 1'b0;
    n_cmp++; if (rvalid !== 1'b1 || err !== 1'b0 || rdata !== 32'h0BAD_F00D) begin n_fail++; $display("FAIL to_next_resp: rvalid %b err %b rdata %h want 1 0 0badf00d", rvalid, err, rdata); end
    tick();
  endtask

  task automatic test_pready_at_limit();
    drive_req(1'b0, 32'h1A10_5000, 4'hF, 32'h0);
    tick(); req = 1'b0; apb.pready = 1'b0;
    tick();
    // pready only on the last allowed ACCESS cycle
    for (int c = 1; c <= int'(TO); c++) begin
      if (c == int'(TO)) begin apb.pready = 1'b1; apb.prdata = 32'h5555_AAAA; apb.pslverr = 1'b0; end
      tick();
    end
    apb.pready = 1'b0;
    n_cmp++; if (rvalid !== 1'b1 || err !== 1'b0 || rdata !== 32'h5555_AAAA) begin n_fail++; $display("FAIL limit_resp: rvalid %b err %b rdata %h want 1 0 5555aaaa", rvalid, err, rdata); end
    tick();
  endtask

  task automatic test_back_to_back();
    apb.pready = 1'b1; apb.pslverr = 1'b0; apb.prdata = 32'h1111_1111;
    drive_req(1'b0, 32'h1A10_6000, 4'hF, 32'h0);
    n_cmp++; if (gnt !== 1'b1) begin n_fail++; $display("FAIL b2b_gnt0: got %b want 1", gnt); end
    tick();
    n_cmp++; if (gnt !== 1'b0) begin n_fail++; $display("FAIL b2b_busy_gnt_setup: got %b want 0", gnt); end
    tick();
    n_cmp++; if (gnt !== 1'b0) begin n_fail++; $display("FAIL b2b_busy_gnt_access: got %b want 0", gnt); end
    tick();
    addr = 32'h1A10_6004; #1;
    n_cmp++; if (rvalid !== 1'b1 || gnt !== 1'b1 || rdata !== 32'h1111_1111) begin n_fail++; $display("FAIL b2b_overlap: rvalid %b gnt %b rdata %h want 1 1 11111111", rvalid, gnt, rdata); end
    tick(); req = 1'b0; apb.prdata = 32'h2222_2222;
    n_cmp++; if (apb.paddr !== 32'h1A10_6004 || apb.psel !== 1'b1) begin n_fail++; $display("FAIL b2b_second_setup: paddr %h psel %b want 1a106004 1", apb.paddr, apb.psel); end
    tick(); tick();
    apb.pready = 1'b0;
    n_cmp++; if (rvalid !== 1'b1 || rdata !== 32'h2222_2222) begin n_fail++; $display("FAIL b2b_second_resp: rvalid %b rdata %h want 1 22222222", rvalid, rdata); end
    tick();
  endtask

  task automatic test_reset_mid();
    drive_req(1'b0, 32'h1A10_7000, 4'hF, 32'h0);
    tick(); req = 1'b0; apb.pready = 1'b0;
    tick();
    n_cmp++; if (apb.psel !== 1'b1 || apb.penable !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre: psel/penable %b%b want 11", apb.psel, apb.penable); end
    #1 rst_n = 1'b0;
    #1;
    n_cmp++; if (apb.psel !== 1'b0 || apb.penable !== 1'b0) begin n_fail++; $display("FAIL rstmid_async_drop: psel/penable %b%b want 00", apb.psel, apb.penable); end
    apb.pready = 1'b1; apb.prdata = 32'h7777_7777;
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      n_cmp++; if (rvalid !== 1'b0 || apb.psel !== 1'b0) begin n_fail++; $display("FAIL rstmid_quiet%0d: rvalid %b psel %b want 0 0", c, rvalid, apb.psel); end
      tick();
    end
    drive_req(1'b0, 32'h1A10_7004, 4'hF, 32'h0);
    tick(); req = 1'b0; apb.prdata = 32'h8888_8888;
    tick();
    n_cmp++; if (rvalid !== 1'b0) begin n_fail++; $display("FAIL rstmid_new_early: got %b want 0", rvalid); end
    tick();
    apb.pready = 1'b0;
    n_cmp++; if (rvalid !== 1'b1 || err !== 1'b0 || rdata !== 32'h8888_8888) begin n_fail++; $display("FAIL rstmid_new_resp: rvalid %b err %b rdata %h want 1 0 88888888", rvalid, err, rdata); end
    tick();
  endtask

  initial begin
    test_reset();
    test_read_zero_wait();
    test_write_waits();
    test_pslverr();
    test_partial_write();
    test_timeout();
    test_pready_at_limit();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_apb_master_bridge
